// File: rtl/rot_w8_inv_pkg.sv
// rot_w8_inv_pkg: shared constants for the W8 rotator (datapath width, 0.7071 constant, shift)
package rot_w8_inv_pkg;
   localparam int NB = 16;
   function automatic int k_of(input int hp);
      return (hp != 0) ? 92677 : 181;
   endfunction
   function automatic int f_of(input int hp);
      return (hp != 0) ? 17 : 8;
   endfunction
   // K < 2^(F+1), so an (nb+3)-bit operand times K fits in nb+4+F bits
   function automatic int pw_of(input int n, input int hp);
      return n + 4 + f_of(hp);
   endfunction
endpackage

// File: rtl/mpu707_full.sv
// mpu707_full: registered shift-add multiply of one signed component by K (full precision, no shift)
//   CLK/RST clock and async reset, EI stage enable, X signed nb+3-bit operand, Y registered X*K
module mpu707_full
   import rot_w8_inv_pkg::*;
#(
   parameter int nb = NB,
   parameter int HIGH_PREC = 0
) (
   input  logic                                   CLK,
   input  logic                                   RST,
   input  logic                                   EI,
   input  logic signed [nb+2:0]                   X,
   output logic signed [pw_of(nb, HIGH_PREC)-1:0] Y
);
   localparam int F = f_of(HIGH_PREC);
   localparam int PW = pw_of(nb, HIGH_PREC);
   localparam logic [31:0] KB = k_of(HIGH_PREC);
   logic signed [PW-1:0] w_x, w_acc;
   assign w_x = {{(PW-nb-3){X[nb+2]}}, X};
   // every set bit of K contributes a full-width shifted copy; nothing is dropped before the final shift
   always_comb begin
      w_acc = '0;
      for (int i = 0; i <= F; i++)
         if (KB[i]) w_acc = w_acc + (w_x <<< i);
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) Y <= '0;
      else if (EI) Y <= w_acc;
endmodule

// File: rtl/rot_w8_inv.sv
// rot_w8_inv: 3-stage complex rotator by W8 (DIR=0) or its conjugate inverse (DIR=1) with saturation
//   CLK/RST clock and async reset, EI pipeline enable, START frame strobe, DIR 0=fwd 1=inv,
//   DR/DI signed input, DOR/DOI saturated output, RDY delayed START, OVF sticky clamp flag
module rot_w8_inv
   import rot_w8_inv_pkg::*;
#(
   parameter int nb = NB,
   parameter int HIGH_PREC = 0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 EI,
   input  logic                 START,
   input  logic                 DIR,
   input  logic signed [nb+1:0] DR,
   input  logic signed [nb+1:0] DI,
   output logic signed [nb+1:0] DOR,
   output logic signed [nb+1:0] DOI,
   output logic                 RDY,
   output logic                 OVF
);
   localparam int F = f_of(HIGH_PREC);
   localparam int PW = pw_of(nb, HIGH_PREC);
   localparam logic signed [PW-1:0] MAXV = {{(PW-nb-1){1'b0}}, {(nb+1){1'b1}}};
   localparam logic signed [PW-1:0] MINV = ~MAXV;
   logic signed [nb+2:0] w_a, w_b, w_sr, w_si, r_sr, r_si;
   logic signed [PW-1:0] w_pr, w_pi, w_qr, w_qi;
   logic signed [nb+1:0] w_dor, w_doi;
   logic                 r_st1, r_st2, w_hr, w_lr, w_hi, w_li, w_clamp;
   // one guard bit so -2^(nb+1) +/- -2^(nb+1) cannot wrap
   assign w_a  = {DR[nb+1], DR};
   assign w_b  = {DI[nb+1], DI};
   assign w_sr = DIR ? w_a - w_b : w_a + w_b;
   assign w_si = DIR ? w_a + w_b : w_b - w_a;
   mpu707_full #(.nb(nb), .HIGH_PREC(HIGH_PREC)) u_mr (
      .CLK(CLK), .RST(RST), .EI(EI), .X(r_sr), .Y(w_pr)
   );
   mpu707_full #(.nb(nb), .HIGH_PREC(HIGH_PREC)) u_mi (
      .CLK(CLK), .RST(RST), .EI(EI), .X(r_si), .Y(w_pi)
   );
   // arithmetic shift floors toward -inf
   assign w_qr    = w_pr >>> F;
   assign w_qi    = w_pi >>> F;
   assign w_hr    = w_qr > MAXV;
   assign w_lr    = w_qr < MINV;
   assign w_hi    = w_qi > MAXV;
   assign w_li    = w_qi < MINV;
   assign w_dor   = w_hr ? MAXV[nb+1:0] : w_lr ? MINV[nb+1:0] : w_qr[nb+1:0];
   assign w_doi   = w_hi ? MAXV[nb+1:0] : w_li ? MINV[nb+1:0] : w_qi[nb+1:0];
   assign w_clamp = w_hr | w_lr | w_hi | w_li;
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         r_sr  <= '0;
         r_si  <= '0;
         r_st1 <= 1'b0;
         r_st2 <= 1'b0;
         DOR   <= '0;
         DOI   <= '0;
         RDY   <= 1'b0;
         OVF   <= 1'b0;
      end else if (EI) begin
         r_sr  <= w_sr;
         r_si  <= w_si;
         r_st1 <= START;
         r_st2 <= r_st1;
         DOR   <= w_dor;
         DOI   <= w_doi;
         RDY   <= r_st2;
         // a new frame clears the flag, but a clamp landing on the same edge wins
         OVF   <= w_clamp | (OVF & ~START);
      end
endmodule

// File: doc/rot_w8_inv.md
Name: rot_w8_inv

Overview:
- Pipelined complex rotator by W8 for the FFT64 datapath; the constant 0.7071 is implemented by shift-add.
- Inverse mode (DIR=1) multiplies by e^{+jπ/4} for the IFFT path. Forward mode (DIR=0) multiplies by e^{-jπ/4}.
- Sits between butterfly stages where the twiddle equals W8 or its conjugate. It replaces a general twiddle multiplier for those points.
- Carries a frame-start strobe alongside the data and flags saturation.

Parameters:
- nb, 16, data width base; complex component ports are nb+2 bits signed.
- HIGH_PREC, 0, 0: K=181, F=8 (0.10110101). 1: K=92677, F=17 (0.10110101000000101).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- EI  in  1  enable; all pipeline registers advance only when EI=1.
- START  in  1  frame-start strobe, sampled with data when EI=1.
- DIR  in  1  0 = forward (conjugate W8), 1 = inverse; sampled with data.
- DR  in  nb+2  real input, signed.
- DI  in  nb+2  imaginary input, signed.
- DOR  out  nb+2  real output, signed.
- DOI  out  nb+2  imaginary output, signed.
- RDY  out  1  START delayed through the pipeline.
- OVF  out  1  sticky saturation flag.

Behaviour:
- Reset (asynchronous, active-high): all pipeline registers, DOR, DOI, RDY and OVF clear to 0 immediately. No output is produced for data that was in flight.
- Arithmetic, with a=DR and b=DI:
  - Forward: sr=a+b, si=b-a.
  - Inverse: sr=a-b, si=a+b.
  - sr and si are nb+3 bits, exact.
  - Products: pr=(sr*K)>>>F and pi=(si*K)>>>F. >>> is arithmetic shift, i.e. floor division.
  - The shift-add implementation must be bit-exact to this formula; partial products must not be truncated early.
- Saturation: each of pr and pi is clamped to [-2^(nb+1), 2^(nb+1)-1]. Any clamp in a cycle sets OVF.
- Pipeline: 3 enabled stages.
  - S1 registers sr, si, START, DIR.
  - S2 registers the full-precision products.
  - S3 registers the saturated DOR/DOI and RDY.
- Latency: a sample accepted on enabled edge n appears on DOR/DOI after enabled edge n+2. That is exactly 3 EI=1 edges, including the capture edge.
- EI=0 freezes every stage, including DOR, DOI and RDY; nothing is lost and nothing is duplicated.
- RDY is a 1-cycle-wide pulse per enabled advance. When EI drops, RDY holds its registered value until the next enabled edge.
- OVF:
  - Sets on the S3 edge whose result clamped.
  - Clears on the S1 edge capturing START=1, unless the same edge's S3 result clamps; set wins.
  - Held otherwise.
- DIR may change every sample; each sample uses its own DIR.
- Boundary behaviour:
  - The most negative input, a=b=-2^(nb+1), must not wrap in sr or si.
  - Consecutive START pulses are each delivered on RDY.
  - RST asserted mid-stream discards in-flight data. The first output after release has latency 3.

Decomposition:
- Shared package/include: K and F per HIGH_PREC; the saturation bounds macro; the datapath width nb (existing fft64 config).
- One sub-module, mpu707_full: a single-component signed multiply by K/2^F. It is a registered, EI-gated shift-add producing a full-precision product. It is instantiated twice, for sr and si (S2).

Test Plan:
- nb=16, HIGH_PREC=0, DIR=1, DR=DI=1000, START=1 → 3 enabled edges later: DOR=0, DOI=1414, RDY=1, OVF=0.
- DIR=0, DR=DI=1000 → DOR=1414, DOI=0. Then DR=-1000, DI=0, DIR=1 → DOR=-708, DOI=-708 (floor check).
- DR=DI=131071, DIR=1 → DOI=131071 (clamped), DOR=0, OVF=1. The next sample with START=1 and no clamp → OVF=0.
- Stream of 8 samples with EI toggling 1,0,0,1,… → output sequence is identical to the EI=1-always run; held values are stable while EI=0.
- Assert RST while 2 samples are in flight → DOR=DOI=RDY=OVF=0 immediately; after release the next input emerges after exactly 3 enabled edges.
- HIGH_PREC=1, DIR=1, DR=DI=1000 → DOI=floor(2000*92677/131072)=1414, DOR=0. Random 10k vectors for both DIR values are compared against the formula model.
